// File: rtl/ocimem_arb_pkg.sv
// Shared types and default widths for the OCI RAM port arbiter.
package ocimem_arb_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        JTAG_RD
    } state_e;

    typedef struct packed {
        logic                  wr;
        logic                  inc;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/ocimem_arb_cmd_fifo.sv
// Small synchronous FIFO of JTAG command structs; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module ocimem_arb_cmd_fifo
    import ocimem_arb_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH_DEF,
    parameter type T     = cmd_t
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    T           r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ocimem_port_arbiter.sv
// Round-robin arbiter for the OCI RAM port between the CPU debug master and
// queued JTAG commands. Define OCIMEM_ARB_AUTOINC_EN for the JTAG auto-increment pointer.
module ocimem_port_arbiter
    import ocimem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic              jtag_inc,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_done,
    output logic              jtag_overflow,
    input  logic              jtag_clr_ovf,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Same layout as cmd_t, sized to this instance's widths.
    typedef struct packed {
        logic              wr;
        logic              inc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } jcmd_t;

    state_e            r_state;
    state_e            w_next;
    logic              r_run;
    logic              r_last_jtag;
    logic              r_done;
    logic              r_ovf;
    logic [DATA_W-1:0] r_rdata;
    jcmd_t             w_push_cmd;
    jcmd_t             w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_cpu_req;
    logic              w_grant_cpu;
    logic              w_grant_jtag;
    logic              w_drop;
    logic [ADDR_W-1:0] w_jtag_addr;

    assign w_push_cmd = '{wr: jtag_wr, inc: jtag_inc, addr: jtag_addr, wdata: jtag_wdata};

    ocimem_arb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (jcmd_t)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (jtag_req),
        .i_data  (w_push_cmd),
        .i_pop   (w_grant_jtag),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef OCIMEM_ARB_AUTOINC_EN
    logic [ADDR_W-1:0] r_ptr;

    assign w_jtag_addr = w_head.inc ? r_ptr : w_head.addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          r_ptr <= '0;
        else if (w_grant_jtag) r_ptr <= w_jtag_addr + 1'b1;
    end
`else
    logic w_unused_inc;

    assign w_unused_inc = w_head.inc;
    assign w_jtag_addr  = w_head.addr;
`endif

    assign w_cpu_req = cpu_read | cpu_write;
    assign w_drop    = jtag_req & w_full & ~w_grant_jtag;

    // Grants are held off until the run flag is set one cycle after reset release.
    always_comb begin
        w_next          = r_state;
        w_grant_cpu     = 1'b0;
        w_grant_jtag    = 1'b0;
        ram_en          = 1'b0;
        ram_wr          = 1'b0;
        ram_addr        = '0;
        ram_wdata       = '0;
        cpu_waitrequest = 1'b1;
        cpu_readdata    = '0;
        case (r_state)
            IDLE: begin
                if (r_run) begin
                    if (w_cpu_req && (w_empty || r_last_jtag)) w_grant_cpu  = 1'b1;
                    else if (!w_empty)                         w_grant_jtag = 1'b1;
                end
                if (w_grant_cpu) begin
                    ram_en    = 1'b1;
                    ram_wr    = cpu_write;
                    ram_addr  = cpu_address;
                    ram_wdata = cpu_writedata;
                    if (cpu_write) cpu_waitrequest = 1'b0;
                    else           w_next          = CPU_RD;
                end else if (w_grant_jtag) begin
                    ram_en    = 1'b1;
                    ram_wr    = w_head.wr;
                    ram_addr  = w_jtag_addr;
                    ram_wdata = w_head.wdata;
                    if (!w_head.wr) w_next = JTAG_RD;
                end
            end
            CPU_RD: begin
                cpu_readdata    = ram_rdata;
                cpu_waitrequest = 1'b0;
                w_next          = IDLE;
            end
            JTAG_RD: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_run       <= 1'b0;
            r_last_jtag <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            r_done  <= (w_grant_jtag && w_head.wr) || (r_state == JTAG_RD);
            r_ovf   <= w_drop || (r_ovf && !jtag_clr_ovf);
            if (w_grant_jtag)           r_last_jtag <= 1'b1;
            else if (w_grant_cpu)       r_last_jtag <= 1'b0;
            if (r_state == JTAG_RD)     r_rdata     <= ram_rdata;
        end
    end

    assign jtag_rdata    = r_rdata;
    assign jtag_done     = r_done;
    assign jtag_overflow = r_ovf;

endmodule

// File: tb/tb_ocimem_port_arbiter.sv
// Directed self-checking bench for ocimem_port_arbiter with a behavioural OCI RAM.
module tb_ocimem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic        jtag_req;
    logic        jtag_wr;
    logic        jtag_inc;
    logic [7:0]  jtag_addr;
    logic [31:0] jtag_wdata;
    logic [31:0] jtag_rdata;
    logic        jtag_done;
    logic        jtag_overflow;
    logic        jtag_clr_ovf;
    logic        ram_en;
    logic        ram_wr;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] mem [256];

    int vectorCount = 0;
    int missCount   = 0;

    ocimem_port_arbiter #(
        .ADDR_W     (8),
        .DATA_W     (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_address     (cpu_address),
        .cpu_writedata   (cpu_writedata),
        .cpu_readdata    (cpu_readdata),
        .cpu_waitrequest (cpu_waitrequest),
        .jtag_req        (jtag_req),
        .jtag_wr         (jtag_wr),
        .jtag_inc        (jtag_inc),
        .jtag_addr       (jtag_addr),
        .jtag_wdata      (jtag_wdata),
        .jtag_rdata      (jtag_rdata),
        .jtag_done       (jtag_done),
        .jtag_overflow   (jtag_overflow),
        .jtag_clr_ovf    (jtag_clr_ovf),
        .ram_en          (ram_en),
        .ram_wr          (ram_wr),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic jtagCmd(input logic req, input logic wr, input logic inc,
                           input logic [7:0] addr, input logic [31:0] wdata);
        jtag_req   = req;
        jtag_wr    = wr;
        jtag_inc   = inc;
        jtag_addr  = addr;
        jtag_wdata = wdata;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        cpu_read      = 1'b0;
        cpu_write     = 1'b1;
        cpu_address   = 8'h10;
        cpu_writedata = 32'hDEADBEEF;
        jtag_clr_ovf  = 1'b0;
        jtagCmd(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        applyStimulus();
        applyStimulus();
        midCycle();
        checkOutput("rst_wait",    32'(cpu_waitrequest), 32'h1);
        checkOutput("rst_ram_en",  32'(ram_en), 32'h0);
        checkOutput("rst_ram_wr",  32'(ram_wr), 32'h0);
        checkOutput("rst_done",    32'(jtag_done), 32'h0);
        checkOutput("rst_ovf",     32'(jtag_overflow), 32'h0);
        checkOutput("rst_jrdata",  jtag_rdata, 32'h0);
        checkOutput("rst_crdata",  cpu_readdata, 32'h0);

        // First cycle after release: run flag not yet set.
        applyStimulus();
        reset_n = 1'b1;
        midCycle();
        checkOutput("run_wait",    32'(cpu_waitrequest), 32'h1);
        checkOutput("run_ram_en",  32'(ram_en), 32'h0);

        applyStimulus();
        midCycle();
        checkOutput("cwr_wait",    32'(cpu_waitrequest), 32'h0);
        checkOutput("cwr_ram_wr",  32'(ram_wr), 32'h1);
        checkOutput("cwr_addr",    32'(ram_addr), 32'h10);
        checkOutput("cwr_wdata",   ram_wdata, 32'hDEADBEEF);

        applyStimulus();
        cpu_write = 1'b0;
        cpu_read  = 1'b1;
        midCycle();
        checkOutput("crd1_ram_wr", 32'(ram_wr), 32'h0);
        checkOutput("crd1_ram_en", 32'(ram_en), 32'h1);
        checkOutput("crd1_wait",   32'(cpu_waitrequest), 32'h1);
        applyStimulus();
        midCycle();
        checkOutput("crd2_wait",   32'(cpu_waitrequest), 32'h0);
        checkOutput("crd2_data",   cpu_readdata, 32'hDEADBEEF);

        // JTAG write then JTAG read of the same word.
        applyStimulus();
        cpu_read = 1'b0;
        jtagCmd(1'b1, 1'b1, 1'b0, 8'h20, 32'h12345678);
        midCycle();
        checkOutput("jwr_lat0",    32'(ram_en), 32'h0);
        applyStimulus();
        jtagCmd(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        midCycle();
        checkOutput("jwr_ram_wr",  32'(ram_wr), 32'h1);
        checkOutput("jwr_addr",    32'(ram_addr), 32'h20);
        checkOutput("jwr_wdata",   ram_wdata, 32'h12345678);
        checkOutput("jwr_done0",   32'(jtag_done), 32'h0);
        applyStimulus();
        jtagCmd(1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        midCycle();
        checkOutput("jwr_done1",   32'(jtag_done), 32'h1);
        applyStimulus();
        jtagCmd(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        midCycle();
        checkOutput("jrd_ram_en",  32'(ram_en), 32'h1);
        checkOutput("jrd_ram_wr",  32'(ram_wr), 32'h0);
        checkOutput("jrd_addr",    32'(ram_addr), 32'h20);
        checkOutput("jrd_done_a",  32'(jtag_done), 32'h0);
        applyStimulus();
        midCycle();
        checkOutput("jrd_done_b",  32'(jtag_done), 32'h0);
        checkOutput("jrd_hold",    jtag_rdata, 32'h0);
        applyStimulus();
        midCycle();
        checkOutput("jrd_done_c",  32'(jtag_done), 32'h1);
        checkOutput("jrd_data",    jtag_rdata, 32'h12345678);

        // CPU reads continuously while two JTAG writes queue up.
        applyStimulus();
        cpu_read    = 1'b1;
        cpu_address = 8'h10;
        jtagCmd(1'b1, 1'b1, 1'b0, 8'h40, 32'h40404040);
        midCycle();
        checkOutput("rr0_addr",    32'(ram_addr), 32'h10);
        checkOutput("rr0_wr",      32'(ram_wr), 32'h0);
        applyStimulus();
        jtagCmd(1'b1, 1'b1, 1'b0, 8'h41, 32'h41414141);
        midCycle();
        checkOutput("rr1_data",    cpu_readdata, 32'hDEADBEEF);
        checkOutput("rr1_ram_en",  32'(ram_en), 32'h0);
        applyStimulus();
        jtagCmd(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        midCycle();
        checkOutput("rr2_jtag_wr", 32'(ram_wr), 32'h1);
        checkOutput("rr2_addr",    32'(ram_addr), 32'h40);
        checkOutput("rr2_wait",    32'(cpu_waitrequest), 32'h1);
        applyStimulus();
        midCycle();
        checkOutput("rr3_cpu_wr",  32'(ram_wr), 32'h0);
        checkOutput("rr3_addr",    32'(ram_addr), 32'h10);
        checkOutput("rr3_done",    32'(jtag_done), 32'h1);
        applyStimulus();
        midCycle();
        checkOutput("rr4_data",    cpu_readdata, 32'hDEADBEEF);
        applyStimulus();
        midCycle();
        checkOutput("rr5_jtag_wr", 32'(ram_wr), 32'h1);
        checkOutput("rr5_addr",    32'(ram_addr), 32'h41);
        applyStimulus();
        midCycle();
        checkOutput("rr6_addr",    32'(ram_addr), 32'h10);
        checkOutput("rr6_done",    32'(jtag_done), 32'h1);
        applyStimulus();
        midCycle();
        checkOutput("rr7_wait",    32'(cpu_waitrequest), 32'h0);

        // Overflow: JTAG read first so the CPU wins the next conflict.
        applyStimulus();
        cpu_read = 1'b0;
        jtagCmd(1'b1, 1'b0, 1'b0, 8'h40, 32'h0);
        midCycle();
        checkOutput("ov_idle",     32'(ram_en), 32'h0);
        applyStimulus();
        cpu_read = 1'b1;
        jtagCmd(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        midCycle();
        checkOutput("ov_jrd_addr", 32'(ram_addr), 32'h40);
        checkOutput("ov_jrd_wr",   32'(ram_wr), 32'h0);
        applyStimulus();
        jtagCmd(1'b1, 1'b1, 1'b0, 8'h50, 32'h50505050);
        midCycle();
        checkOutput("ov_jtagrd",   32'(ram_en), 32'h0);
        applyStimulus();
        jtagCmd(1'b1, 1'b1, 1'b0, 8'h51, 32'h51515151);
        midCycle();
        checkOutput("ov_cpu_addr", 32'(ram_addr), 32'h10);
        checkOutput("ov_rdone",    32'(jtag_done), 32'h1);
        checkOutput("ov_rdata",    jtag_rdata, 32'h40404040);
        applyStimulus();
        jtagCmd(1'b1, 1'b1, 1'b0, 8'h52, 32'h52525252);
        midCycle();
        checkOutput("ov_cpu_data", cpu_readdata, 32'hDEADBEEF);
        checkOutput("ov_pre",      32'(jtag_overflow), 32'h0);
        applyStimulus();
        cpu_read = 1'b0;
        jtagCmd(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        midCycle();
        checkOutput("ov_set",      32'(jtag_overflow), 32'h1);
        checkOutput("ov_q1_addr",  32'(ram_addr), 32'h50);
        checkOutput("ov_q1_data",  ram_wdata, 32'h50505050);
        applyStimulus();
        midCycle();
        checkOutput("ov_q2_addr",  32'(ram_addr), 32'h51);
        applyStimulus();
        midCycle();
        checkOutput("ov_dropped",  32'(ram_en), 32'h0);
        checkOutput("ov_sticky",   32'(jtag_overflow), 32'h1);
        applyStimulus();
        jtag_clr_ovf = 1'b1;
        midCycle();
        checkOutput("ov_clr_lat",  32'(jtag_overflow), 32'h1);
        applyStimulus();
        jtag_clr_ovf = 1'b0;
        midCycle();
        checkOutput("ov_cleared",  32'(jtag_overflow), 32'h0);

        // Pointer wrap (or inc ignored when auto-increment is not built in).
        applyStimulus();
        jtagCmd(1'b1, 1'b1, 1'b0, 8'hFF, 32'hFFFF0001);
        applyStimulus();
        jtagCmd(1'b1, 1'b1, 1'b1, 8'h33, 32'h00000002);
        midCycle();
        checkOutput("ai_first",    32'(ram_addr), 32'hFF);
        applyStimulus();
        jtagCmd(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        midCycle();
`ifdef OCIMEM_ARB_AUTOINC_EN
        checkOutput("ai_wrap",     32'(ram_addr), 32'h00);
`else
        checkOutput("ai_ignored",  32'(ram_addr), 32'h33);
`endif
        checkOutput("ai_wdata",    ram_wdata, 32'h00000002);

        // Reset asserted while in JTAG_RD.
        applyStimulus();
        jtagCmd(1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        applyStimulus();
        jtagCmd(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        midCycle();
        checkOutput("mr_grant",    32'(ram_addr), 32'h20);
        applyStimulus();
        #1;
        reset_n       = 1'b0;
        cpu_write     = 1'b1;
        cpu_address   = 8'h60;
        cpu_writedata = 32'h60606060;
        midCycle();
        checkOutput("mr_done",     32'(jtag_done), 32'h0);
        checkOutput("mr_ram_en",   32'(ram_en), 32'h0);
        checkOutput("mr_wait",     32'(cpu_waitrequest), 32'h1);
        checkOutput("mr_jrdata",   jtag_rdata, 32'h0);
        checkOutput("mr_crdata",   cpu_readdata, 32'h0);
        applyStimulus();
        midCycle();
        checkOutput("mr_done2",    32'(jtag_done), 32'h0);
        applyStimulus();
        reset_n = 1'b1;
        midCycle();
        checkOutput("mr_rel_wait", 32'(cpu_waitrequest), 32'h1);
        checkOutput("mr_rel_en",   32'(ram_en), 32'h0);
        checkOutput("mr_rel_done", 32'(jtag_done), 32'h0);
        applyStimulus();
        midCycle();
        checkOutput("mr_run_wait", 32'(cpu_waitrequest), 32'h0);
        checkOutput("mr_run_addr", 32'(ram_addr), 32'h60);
        checkOutput("mr_run_done", 32'(jtag_done), 32'h0);
        applyStimulus();
        cpu_write = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/ocimem_port_arbiter.md
# ocimem_port_arbiter

Arbitrates the single port of the Nios II on-chip debug memory (OCI RAM, 256 x 32) between two requesters:
- the CPU-side debug-monitor data master;
- JTAG-originated memory commands arriving from the debug-slave sysclk domain as single-cycle action pulses.

JTAG commands are buffered in a small FIFO so bursts of take-action pulses are never lost while the CPU holds the port. Requesters are served round-robin on conflict. The block sits between the debug-slave wrapper outputs and the OCI RAM inside the CPU debug module.

## Interface
Parameters:
- ADDR_W, 8, OCI RAM word-address width
- DATA_W, 32, data width
- FIFO_DEPTH, 2, JTAG command FIFO entries; power of two, ≥2

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_read  in  1  CPU read request, held until accepted
- cpu_write  in  1  CPU write request, held until accepted
- cpu_address  in  ADDR_W  CPU word address
- cpu_writedata  in  DATA_W  CPU write data
- cpu_readdata  out  DATA_W  CPU read data; valid when cpu_read=1 and cpu_waitrequest=0
- cpu_waitrequest  out  1  stall to CPU
- jtag_req  in  1  single-cycle command strobe
- jtag_wr  in  1  1 = write, 0 = read
- jtag_inc  in  1  use and post-increment the internal auto-increment pointer
- jtag_addr  in  ADDR_W  explicit address; also loads the pointer
- jtag_wdata  in  DATA_W  write data
- jtag_rdata  out  DATA_W  last JTAG read result; held until the next JTAG read completes
- jtag_done  out  1  one-cycle completion pulse
- jtag_overflow  out  1  sticky: a command was dropped
- jtag_clr_ovf  in  1  clears jtag_overflow
- ram_en, ram_wr  out  1  RAM access enable and write
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency

## Operation
- States:
  - IDLE: grant decision
  - CPU_RD: CPU read data return
  - JTAG_RD: JTAG read data capture
- IDLE, grant rules:
  - Candidates are a CPU request (cpu_read|cpu_write) and a non-empty FIFO.
  - Only one candidate present: it wins.
  - Both present: the requester not granted last time wins. The last-grant bit resets to CPU, so JTAG wins the first conflict.
- Grant actions:
  - Granted write: RAM write issued; return to IDLE.
  - Granted CPU read: RAM read issued, go to CPU_RD.
  - Granted JTAG read: RAM read issued, go to JTAG_RD.
- CPU_RD: cpu_readdata = ram_rdata, cpu_waitrequest = 0; then IDLE.
- JTAG_RD: jtag_rdata <= ram_rdata; then IDLE.
- No grant is made in CPU_RD or JTAG_RD.
- cpu_waitrequest:
  - Drops combinationally for a CPU write granted in IDLE.
  - Drops in CPU_RD for a read.
  - Is 1 otherwise whenever the CPU requests.
- FIFO:
  - Push on jtag_req; pop on JTAG grant.
  - jtag_req while full is dropped and sets jtag_overflow, unless a pop occurs in the same cycle, in which case it is accepted.
  - jtag_clr_ovf coincident with a drop: set wins.
- JTAG address: jtag_inc=0 uses jtag_addr and loads the pointer with jtag_addr+1. jtag_inc=1 uses the pointer and post-increments it, wrapping 2^ADDR_W−1 → 0. The pointer is resolved at pop time.
- ram_* outputs are combinational from the IDLE grant; ram_en=0 when nothing is granted.

## Timing
- CPU write: 1 cycle when uncontested.
- CPU read: 2 cycles (grant, then data).
- JTAG write: jtag_done 1 cycle after the RAM write cycle.
- JTAG read: jtag_done asserted in the cycle after JTAG_RD, with jtag_rdata already valid.
- Minimum latency from jtag_req to RAM access: 1 cycle (FIFO registered).
- Reset values:
  - state IDLE, FIFO empty, pointer 0, last-grant CPU
  - jtag_rdata 0, jtag_done 0, jtag_overflow 0
  - ram_en 0, ram_wr 0, cpu_readdata 0
- cpu_waitrequest is 1 during reset and in the first cycle after release (registered run flag).
- Reset mid-read discards the access; no jtag_done pulse is produced.

## Configuration
- OCIMEM_ARB_AUTOINC_EN
  - Defined: jtag_inc and the pointer behave as above.
  - Undefined: the pointer is removed, jtag_inc is ignored, and every JTAG command uses jtag_addr.

## Structure
- Package ocimem_arb_pkg:
  - state enum (IDLE, CPU_RD, JTAG_RD)
  - command struct {wr, inc, addr, wdata}
  - default width constants
- Sub-module ocimem_arb_cmd_fifo: a synchronous FIFO of command structs with full/empty and simultaneous push/pop.

## Test plan
- CPU write 0xDEADBEEF to 0x10, then read 0x10: write accepted in 1 cycle; read returns 0xDEADBEEF with cpu_waitrequest low in cycle 2.
- JTAG write 0x12345678 to 0x20, then JTAG read 0x20: two jtag_done pulses; jtag_rdata = 0x12345678 at the second.
- CPU reading continuously while 2 JTAG writes are queued: grants alternate JTAG, CPU, JTAG, CPU; no starvation.
- 3 jtag_req pulses in consecutive cycles while the CPU holds the port: first two queued, third dropped, jtag_overflow=1; stays set until jtag_clr_ovf.
- With OCIMEM_ARB_AUTOINC_EN: write to 0xFF (inc=0), then write with inc=1: second write lands at 0x00.
- Reset asserted in JTAG_RD: no jtag_done; all outputs at reset values; cpu_waitrequest=1 until one cycle after release.
